// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS CPU memory arbiter: FSM state encoding and requester ids.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_e;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

endpackage

// File: rtl/mips_cpu_arb_picker.sv
// Grant select between fetch and data requesters plus the tie-break pointer.
// Macro MIPS_CPU_ARB_ROUND_ROBIN_EN: alternate ties; otherwise data always wins a tie.
module mips_cpu_arb_picker
    import mips_cpu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    input  logic advance,
    output logic grant_any,
    output logic grant_id
);

    logic prio_q;
    logic prio_d;
    logic rr_next;

    // Without round-robin the pointer is pinned to data, giving fixed priority.
`ifdef MIPS_CPU_ARB_ROUND_ROBIN_EN
    assign rr_next = ~grant_id;
`else
    assign rr_next = REQ_DATA;
`endif

    always_comb begin
        grant_any = i_req | d_req;
        grant_id  = REQ_FETCH;
        if (i_req && d_req) begin
            grant_id = prio_q;
        end else if (d_req) begin
            grant_id = REQ_DATA;
        end

        prio_d = prio_q;
        if (advance) begin
            prio_d = rr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= REQ_DATA;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// Two-requester (fetch/data) arbiter driving a single Avalon-MM master port.
// Optional macro MIPS_CPU_ARB_ROUND_ROBIN_EN selects alternating tie-break.
module mips_cpu_mem_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        err
);

    localparam int unsigned CNT_W = (WAIT_LIMIT > 255) ? $clog2(WAIT_LIMIT + 1) : 8;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    arb_state_e       state_q, state_d;
    logic             id_q, id_d;
    logic [31:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             err_q, err_d;

    logic grant_any;
    logic grant_id;
    logic advance;
    logic in_issue;
    logic in_resp;

    assign advance = (state_q == IDLE) && grant_any;

    mips_cpu_arb_picker u_picker (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .d_req     (d_req),
        .advance   (advance),
        .grant_any (grant_any),
        .grant_id  (grant_id)
    );

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        stall_cnt_d = stall_cnt_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d     = ISSUE;
                    id_d        = grant_id;
                    stall_cnt_d = '0;
                    if (grant_id == REQ_DATA) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        be_d    = d_be;
                    end else begin
                        addr_d  = i_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        be_d    = '1;
                    end
                end
            end
            ISSUE: begin
                if (waitrequest) begin
                    if (stall_cnt_q != '1) begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                    // Stall limit only flags; the transfer keeps waiting.
                    if (stall_cnt_d >= LIMIT) begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        in_issue   = (state_q == ISSUE);
        in_resp    = (state_q == RESP);
        read       = in_issue & ~we_q;
        write      = in_issue & we_q;
        address    = in_issue ? (addr_q & 32'hFFFF_FFFC) : '0;
        byteenable = in_issue ? (we_q ? be_q : 4'b1111) : '0;
        writedata  = (in_issue && we_q) ? wdata_q : '0;
        i_valid    = in_resp && (id_q == REQ_FETCH);
        d_valid    = in_resp && (id_q == REQ_DATA);
        i_rdata    = i_valid ? readdata : '0;
        d_rdata    = (d_valid && !we_q) ? readdata : '0;
        err        = err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            id_q        <= REQ_DATA;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Self-checking bench for mips_cpu_mem_arbiter: directed cases then randomized transactions.
module tb_mips_cpu_mem_arbiter;

    localparam int unsigned LIM = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = '0;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Reference model state: sticky error flag and who was granted last.
    bit err_exp = 1'b0;
    bit last_data = 1'b0;

    mips_cpu_mem_arbiter #(.WAIT_LIMIT(LIM)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_valid     (i_valid),
        .i_rdata     (i_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_be        (d_be),
        .d_valid     (d_valid),
        .d_rdata     (d_rdata),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        err_exp = 1'b0;
        last_data = 1'b0;
    endtask

    function automatic bit tie_goes_to_data();
`ifdef MIPS_CPU_ARB_ROUND_ROBIN_EN
        return !last_data;
`else
        return 1'b1;
`endif
    endfunction

    // Called in IDLE with the requests already driven; checks the whole transfer.
    task automatic serve(input bit win_d, input int unsigned stalls, input logic [31:0] rd);
        logic [31:0] ea;
        logic [31:0] ewd;
        logic [3:0]  ebe;
        logic        ew;
        int unsigned cnt;
        ew  = win_d ? d_we : 1'b0;
        ea  = (win_d ? d_addr : i_addr) & ~32'd3;
        ebe = ew ? d_be : 4'hF;
        ewd = ew ? d_wdata : 32'd0;
        cnt = 0;
        tick();
        last_data = win_d;
        for (int unsigned k = 0; k <= stalls; k++) begin
            waitrequest = (k < stalls);
            readdata = $urandom;
            #1;
            chk("issue_read", {31'd0, read}, {31'd0, !ew});
            chk("issue_write", {31'd0, write}, {31'd0, ew});
            chk("issue_address", address, ea);
            chk("issue_byteenable", {28'd0, byteenable}, {28'd0, ebe});
            chk("issue_writedata", writedata, ewd);
            chk("issue_valids", {30'd0, i_valid, d_valid}, 32'd0);
            chk("issue_err", {31'd0, err}, {31'd0, err_exp});
            tick();
            if (k < stalls) begin
                cnt++;
                if (cnt >= LIM) err_exp = 1'b1;
            end
        end
        waitrequest = 1'($urandom);
        readdata = rd;
        #1;
        chk("resp_rw", {30'd0, read, write}, 32'd0);
        chk("resp_i_valid", {31'd0, i_valid}, {31'd0, !win_d});
        chk("resp_d_valid", {31'd0, d_valid}, {31'd0, win_d});
        if (!win_d) chk("resp_i_rdata", i_rdata, rd);
        else if (!ew) chk("resp_d_rdata", d_rdata, rd);
        chk("resp_err", {31'd0, err}, {31'd0, err_exp});
        if (win_d) d_req = 1'b0;
        else i_req = 1'b0;
        waitrequest = 1'b0;
        tick();
        chk("idle_valids", {30'd0, i_valid, d_valid}, 32'd0);
        chk("idle_rw", {30'd0, read, write}, 32'd0);
    endtask

    initial begin
        bit w;
        int unsigned st;
        int unsigned mode;

        // Reset state
        do_reset();
        do_reset();
        chk("rst_rw", {30'd0, read, write}, 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_byteenable", {28'd0, byteenable}, 32'd0);
        chk("rst_writedata", writedata, 32'd0);
        chk("rst_valids", {30'd0, i_valid, d_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // Zero-wait fetch read
        i_addr = 32'hBFC00003;
        i_req = 1'b1;
        serve(1'b0, 0, 32'h24020005);

        // Data write with three stall cycles
        d_addr = 32'h00001004; d_wdata = 32'hDEADBEEF; d_be = 4'b0011; d_we = 1'b1;
        d_req = 1'b1;
        serve(1'b1, 3, 32'h0);

        // Simultaneous requests, then a second tie with fetch still pending
        do_reset();
        i_addr = 32'h00400010; d_addr = 32'h10000020; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        serve(1'b1, 0, 32'h11111111);
        d_addr = 32'h10000024;
        d_req = 1'b1;
        w = tie_goes_to_data();
        serve(w, 1, 32'h22222222);
        serve(!w, 0, 32'h33333333);

        // Stall limit: err rises after the LIM-th stall and stays set
        d_we = 1'b0; d_addr = 32'h00002000; d_req = 1'b1;
        serve(1'b1, 6, 32'hCAFEF00D);
        chk("err_after_limit", {31'd0, err}, 32'd1);
        i_req = 1'b1;
        serve(1'b0, 0, 32'h0BADF00D);
        chk("err_sticky", {31'd0, err}, 32'd1);
        do_reset();
        chk("err_cleared", {31'd0, err}, 32'd0);

        // Reset during ISSUE drops the transfer
        i_addr = 32'h00000040; i_req = 1'b1; waitrequest = 1'b1;
        tick();
        chk("mid_read", {31'd0, read}, 32'd1);
        i_req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        err_exp = 1'b0; last_data = 1'b0;
        waitrequest = 1'b0;
        chk("mid_rst_rw", {30'd0, read, write}, 32'd0);
        chk("mid_rst_address", address, 32'd0);
        tick();
        chk("mid_rst_novalid", {30'd0, i_valid, d_valid}, 32'd0);
        chk("mid_rst_idle", {30'd0, read, write}, 32'd0);
        i_req = 1'b1;
        serve(1'b0, 2, 32'h5A5A5A5A);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            d_be = 4'($urandom); d_we = 1'($urandom);
            st = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                i_req = 1'b1;
                serve(1'b0, st, $urandom);
            end else if (mode == 1) begin
                d_req = 1'b1;
                serve(1'b1, st, $urandom);
            end else begin
                i_req = 1'b1; d_req = 1'b1;
                w = tie_goes_to_data();
                serve(w, st, $urandom);
                serve(!w, $urandom_range(0, 2), $urandom);
            end
            if ($urandom_range(0, 5) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
